// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin arbiter that shares one L2 cache port
// between the instruction-side and data-side L1 miss paths.
module l2_arbiter (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_mem_read,
  input  logic         i_mem_write,
  input  logic [15:0]  i_mem_address,
  input  logic [127:0] i_mem_wdata,
  output logic         i_mem_resp,
  output logic [127:0] i_mem_rdata,
  input  logic         d_mem_read,
  input  logic         d_mem_write,
  input  logic [15:0]  d_mem_address,
  input  logic [127:0] d_mem_wdata,
  output logic         d_mem_resp,
  output logic [127:0] d_mem_rdata,
  output logic         l2_mem_read,
  output logic         l2_mem_write,
  output logic [15:0]  l2_mem_address,
  output logic [127:0] l2_mem_wdata,
  input  logic         l2_mem_resp,
  input  logic [127:0] l2_mem_rdata,
  output logic [15:0]  conflict_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        last_grant_q;
  logic [15:0] conflict_q;
  logic        i_req;
  logic        d_req;
  logic        both_req;
  logic        i_only;
  logic        d_only;
  logic        arb_conflict;

  assign i_req    = i_mem_read | i_mem_write;
  assign d_req    = d_mem_read | d_mem_write;
  assign both_req = i_req & d_req;
  assign i_only   = i_req & ~d_req;
  assign d_only   = d_req & ~i_req;

  assign arb_conflict = (state_q == IDLE) & both_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      conflict_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == SERVE_I)
        last_grant_q <= 1'b0;
      if (state_q == IDLE && state_d == SERVE_D)
        last_grant_q <= 1'b1;
      if (arb_conflict && conflict_q != 16'hFFFF)
        conflict_q <= conflict_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          both_req: state_d = last_grant_q ? SERVE_I : SERVE_D;
          i_only:   state_d = SERVE_I;
          d_only:   state_d = SERVE_D;
          default:  state_d = IDLE;
        endcase
      end
      SERVE_I: if (l2_mem_resp) state_d = IDLE;
      SERVE_D: if (l2_mem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port I values sit on the L2 bus while idle; strobes stay low.
  always_comb begin
    l2_mem_read    = 1'b0;
    l2_mem_write   = 1'b0;
    l2_mem_address = i_mem_address;
    l2_mem_wdata   = i_mem_wdata;
    i_mem_resp     = 1'b0;
    d_mem_resp     = 1'b0;
    unique case (state_q)
      SERVE_I: begin
        l2_mem_read  = i_mem_read;
        l2_mem_write = i_mem_write;
        i_mem_resp   = l2_mem_resp;
      end
      SERVE_D: begin
        l2_mem_read    = d_mem_read;
        l2_mem_write   = d_mem_write;
        l2_mem_address = d_mem_address;
        l2_mem_wdata   = d_mem_wdata;
        d_mem_resp     = l2_mem_resp;
      end
      default: ;
    endcase
  end

  assign i_mem_rdata    = l2_mem_rdata;
  assign d_mem_rdata    = l2_mem_rdata;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbiter.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_mem_read = 1'b0;
  logic         i_mem_write = 1'b0;
  logic [15:0]  i_mem_address = '0;
  logic [127:0] i_mem_wdata = '0;
  logic         i_mem_resp;
  logic [127:0] i_mem_rdata;
  logic         d_mem_read = 1'b0;
  logic         d_mem_write = 1'b0;
  logic [15:0]  d_mem_address = '0;
  logic [127:0] d_mem_wdata = '0;
  logic         d_mem_resp;
  logic [127:0] d_mem_rdata;
  logic         l2_mem_read;
  logic         l2_mem_write;
  logic [15:0]  l2_mem_address;
  logic [127:0] l2_mem_wdata;
  logic         l2_mem_resp = 1'b0;
  logic [127:0] l2_mem_rdata = '0;
  logic [15:0]  conflict_count;

  int checks = 0;
  int errors = 0;

  l2_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_mem_read     (i_mem_read),
    .i_mem_write    (i_mem_write),
    .i_mem_address  (i_mem_address),
    .i_mem_wdata    (i_mem_wdata),
    .i_mem_resp     (i_mem_resp),
    .i_mem_rdata    (i_mem_rdata),
    .d_mem_read     (d_mem_read),
    .d_mem_write    (d_mem_write),
    .d_mem_address  (d_mem_address),
    .d_mem_wdata    (d_mem_wdata),
    .d_mem_resp     (d_mem_resp),
    .d_mem_rdata    (d_mem_rdata),
    .l2_mem_read    (l2_mem_read),
    .l2_mem_write   (l2_mem_write),
    .l2_mem_address (l2_mem_address),
    .l2_mem_wdata   (l2_mem_wdata),
    .l2_mem_resp    (l2_mem_resp),
    .l2_mem_rdata   (l2_mem_rdata),
    .conflict_count (conflict_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    l2_mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    i_mem_read  = 1'b1;
    d_mem_write = 1'b1;
    l2_mem_resp = 1'b1;
    @(negedge clk);
    checks++;
    if ({l2_mem_read, l2_mem_write} !== 2'b00) begin
      errors++;
      $display("FAIL reset_l2 rd/wr=%b exp=00",
               {l2_mem_read, l2_mem_write});
    end
    checks++;
    if ({i_mem_resp, d_mem_resp} !== 2'b00) begin
      errors++;
      $display("FAIL reset_resp i/d=%b exp=00",
               {i_mem_resp, d_mem_resp});
    end
    checks++;
    if (conflict_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt got=%h exp=0000", conflict_count);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    logic [127:0] rd;
    logic e_rd;
    logic e_rs;
    do_reset();
    rd = {$urandom, $urandom, $urandom, $urandom};
    l2_mem_rdata  = rd;
    i_mem_address = 16'h1230;
    for (int c = 0; c <= 6; c++) begin
      i_mem_read  = 1'b1;
      l2_mem_resp = (c == 4 || c == 6);
      @(negedge clk);
      e_rd = (c >= 1 && c <= 4) || c == 6;
      e_rs = (c == 4 || c == 6);
      checks++;
      if (l2_mem_read !== e_rd) begin
        errors++;
        $display("FAIL single_rd c=%0d l2_read=%b exp=%b",
                 c, l2_mem_read, e_rd);
      end
      checks++;
      if (i_mem_resp !== e_rs) begin
        errors++;
        $display("FAIL single_resp c=%0d i_resp=%b exp=%b",
                 c, i_mem_resp, e_rs);
      end
      if (c == 1) begin
        checks++;
        if (l2_mem_address !== 16'h1230) begin
          errors++;
          $display("FAIL single_addr got=%h exp=1230",
                   l2_mem_address);
        end
      end
      if (c == 4) begin
        checks++;
        if (i_mem_rdata !== rd) begin
          errors++;
          $display("FAIL single_rdata got=%h exp=%h",
                   i_mem_rdata, rd);
        end
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_conflict();
    logic [127:0] dw;
    logic [1:0] e_rw;
    logic [1:0] e_rs;
    do_reset();
    dw = {$urandom, $urandom, $urandom, $urandom};
    i_mem_address = 16'h1111;
    d_mem_address = 16'h2222;
    d_mem_wdata   = dw;
    for (int c = 0; c <= 5; c++) begin
      i_mem_read  = (c <= 2);
      d_mem_write = (c <= 4);
      l2_mem_resp = (c == 2 || c == 4);
      @(negedge clk);
      e_rw = {(c == 1 || c == 2), (c == 4)};
      e_rs = {(c == 2), (c == 4)};
      checks++;
      if ({l2_mem_read, l2_mem_write} !== e_rw) begin
        errors++;
        $display("FAIL conflict_rw c=%0d got=%b exp=%b",
                 c, {l2_mem_read, l2_mem_write}, e_rw);
      end
      checks++;
      if ({i_mem_resp, d_mem_resp} !== e_rs) begin
        errors++;
        $display("FAIL conflict_resp c=%0d got=%b exp=%b",
                 c, {i_mem_resp, d_mem_resp}, e_rs);
      end
      if (c == 1) begin
        checks++;
        if (l2_mem_address !== 16'h1111 ||
            conflict_count !== 16'd1) begin
          errors++;
          $display("FAIL conflict_first addr=%h cnt=%0d exp=1111/1",
                   l2_mem_address, conflict_count);
        end
      end
      if (c == 4) begin
        checks++;
        if (l2_mem_address !== 16'h2222 || l2_mem_wdata !== dw) begin
          errors++;
          $display("FAIL conflict_dwr addr=%h wd=%h exp=2222/%h",
                   l2_mem_address, l2_mem_wdata, dw);
        end
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_alternate();
    logic [15:0] e_addr;
    do_reset();
    i_mem_address = 16'h1000;
    d_mem_address = 16'h2000;
    i_mem_read = 1'b1;
    d_mem_read = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      l2_mem_resp = (c % 2 == 1);
      @(negedge clk);
      if (c % 2 == 1) begin
        e_addr = (c % 4 == 1) ? 16'h1000 : 16'h2000;
        checks++;
        if (l2_mem_address !== e_addr ||
            {i_mem_resp, d_mem_resp} !== {c % 4 == 1, c % 4 == 3}) begin
          errors++;
          $display("FAIL alt_grant c=%0d addr=%h resp=%b exp=%h",
                   c, l2_mem_address, {i_mem_resp, d_mem_resp}, e_addr);
        end
      end else begin
        checks++;
        if (l2_mem_read !== 1'b0) begin
          errors++;
          $display("FAIL alt_idle c=%0d l2_read=%b exp=0",
                   c, l2_mem_read);
        end
      end
      if (c == 8) begin
        checks++;
        if (conflict_count !== 16'd4) begin
          errors++;
          $display("FAIL alt_cnt got=%0d exp=4", conflict_count);
        end
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_d_write();
    logic [127:0] pat;
    logic e_wr;
    do_reset();
    pat = {16{8'hA5}};
    i_mem_address = 16'h7777;
    d_mem_address = 16'h4000;
    d_mem_wdata   = pat;
    for (int c = 0; c <= 3; c++) begin
      d_mem_write = (c <= 2);
      l2_mem_resp = (c == 2);
      @(negedge clk);
      e_wr = (c == 1 || c == 2);
      checks++;
      if (l2_mem_write !== e_wr || l2_mem_read !== 1'b0) begin
        errors++;
        $display("FAIL dwr_strobe c=%0d wr=%b rd=%b exp=%b/0",
                 c, l2_mem_write, l2_mem_read, e_wr);
      end
      checks++;
      if (i_mem_resp !== 1'b0) begin
        errors++;
        $display("FAIL dwr_iresp c=%0d got=%b exp=0", c, i_mem_resp);
      end
      if (e_wr) begin
        checks++;
        if (l2_mem_address !== 16'h4000 || l2_mem_wdata !== pat) begin
          errors++;
          $display("FAIL dwr_data c=%0d addr=%h wd=%h",
                   c, l2_mem_address, l2_mem_wdata);
        end
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_mem_address = 16'h3333;
    d_mem_read = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (l2_mem_read !== 1'b1 || l2_mem_address !== 16'h3333) begin
      errors++;
      $display("FAIL rstmid_serve rd=%b addr=%h exp=1/3333",
               l2_mem_read, l2_mem_address);
    end
    #1;
    l2_mem_resp = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({l2_mem_read, d_mem_resp, i_mem_resp} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_async rd/dr/ir=%b exp=000",
               {l2_mem_read, d_mem_resp, i_mem_resp});
    end
    tick();
    reset_n = 1'b1;
    clear_inputs();
    i_mem_address = 16'h5555;
    i_mem_read = 1'b1;
    @(negedge clk);
    checks++;
    if (l2_mem_read !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle rd=%b exp=0", l2_mem_read);
    end
    tick();
    l2_mem_resp = 1'b1;
    @(negedge clk);
    checks++;
    if (l2_mem_read !== 1'b1 || l2_mem_address !== 16'h5555 ||
        i_mem_resp !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_newreq rd=%b addr=%h ir=%b exp=1/5555/1",
               l2_mem_read, l2_mem_address, i_mem_resp);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    // Skip ahead to one below the ceiling instead of 65535 real conflicts.
    dut.conflict_q = 16'hFFFE;
    i_mem_read = 1'b1;
    d_mem_read = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      l2_mem_resp = (c % 2 == 1);
      @(negedge clk);
      if (c % 2 == 1) begin
        checks++;
        if (conflict_count !== 16'hFFFF) begin
          errors++;
          $display("FAIL sat_cnt c=%0d got=%h exp=ffff",
                   c, conflict_count);
        end
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int owner;
    bit last_d;
    int cnt;
    bit i_pend;
    bit d_pend;
    logic [3:0] e_ctl;
    logic [15:0] e_addr;
    logic [127:0] e_wd;
    do_reset();
    owner = 0;
    last_d = 1'b1;
    cnt = 0;
    i_pend = 1'b0;
    d_pend = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!i_pend) begin
        i_mem_address = 16'($urandom);
        i_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 2) == 0) begin
          i_pend = 1'b1;
          {i_mem_read, i_mem_write} = 2'($urandom_range(1, 3));
        end else begin
          {i_mem_read, i_mem_write} = 2'b00;
        end
      end
      if (!d_pend) begin
        d_mem_address = 16'($urandom);
        d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 2) == 0) begin
          d_pend = 1'b1;
          {d_mem_read, d_mem_write} = 2'($urandom_range(1, 3));
        end else begin
          {d_mem_read, d_mem_write} = 2'b00;
        end
      end
      l2_mem_resp = ($urandom_range(0, 2) == 0);
      l2_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      e_ctl = 4'b0000;
      e_addr = i_mem_address;
      e_wd = i_mem_wdata;
      if (owner == 1) begin
        e_ctl = {i_mem_read, i_mem_write, l2_mem_resp, 1'b0};
      end else if (owner == 2) begin
        e_ctl = {d_mem_read, d_mem_write, 1'b0, l2_mem_resp};
        e_addr = d_mem_address;
        e_wd = d_mem_wdata;
      end
      checks++;
      if ({l2_mem_read, l2_mem_write, i_mem_resp, d_mem_resp} !== e_ctl) begin
        errors++;
        $display("FAIL rand_ctl n=%0d rd/wr/ir/dr=%b exp=%b", n,
                 {l2_mem_read, l2_mem_write, i_mem_resp, d_mem_resp},
                 e_ctl);
      end
      checks++;
      if (l2_mem_address !== e_addr || l2_mem_wdata !== e_wd) begin
        errors++;
        $display("FAIL rand_bus n=%0d addr=%h exp=%h", n,
                 l2_mem_address, e_addr);
      end
      checks++;
      if (i_mem_rdata !== l2_mem_rdata || d_mem_rdata !== l2_mem_rdata) begin
        errors++;
        $display("FAIL rand_rdata n=%0d i=%h d=%h exp=%h", n,
                 i_mem_rdata, d_mem_rdata, l2_mem_rdata);
      end
      checks++;
      if (conflict_count !== 16'(cnt)) begin
        errors++;
        $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n,
                 conflict_count, cnt);
      end
      if (owner == 0) begin
        if (i_pend && d_pend) begin
          if (cnt < 65535) cnt++;
          owner = last_d ? 1 : 2;
        end else if (i_pend) begin
          owner = 1;
        end else if (d_pend) begin
          owner = 2;
        end
        if (owner != 0) last_d = (owner == 2);
      end else if (l2_mem_resp) begin
        if (owner == 1) i_pend = 1'b0;
        else d_pend = 1'b0;
        owner = 0;
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_conflict();
    test_alternate();
    test_d_write();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
